// File: rtl/boid_fb_writer_if.sv
// Boid request stream, frame control pulses and frame-buffer RAM write port
// of the boid frame-buffer writer, bundled so both ends share one definition.
interface boid_fb_writer_if #(
    parameter int X_WIDTH       = 8,
    parameter int Y_WIDTH       = 7,
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8
) ();
    logic                     frame_start;
    logic                     boid_valid;
    logic                     boid_ready;
    logic [X_WIDTH-1:0]       boid_x;
    logic [Y_WIDTH-1:0]       boid_y;
    logic [DATA_WIDTH-1:0]    boid_color;
    logic                     ram_wEn;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic                     busy;
    logic                     clear_done;

    // Side that issues frames and boids and observes the RAM write port
    modport master (
        output frame_start, boid_valid, boid_x, boid_y, boid_color,
        input  boid_ready, ram_wEn, ram_addr, ram_dataIn, busy, clear_done
    );

    // Writer side: consumes frames and boids, drives the RAM write port
    modport slave (
        input  frame_start, boid_valid, boid_x, boid_y, boid_color,
        output boid_ready, ram_wEn, ram_addr, ram_dataIn, busy, clear_done
    );
endinterface

// File: rtl/boid_fb_writer.sv
// Frame-buffer write-port driver: clears the whole buffer on frame_start, then
// plots each accepted boid as a SIZE x SIZE square, one registered write per clock.
module boid_fb_writer #(
    parameter int                    SCREEN_W      = 160,
    parameter int                    SCREEN_H      = 120,
    parameter int                    X_WIDTH       = 8,
    parameter int                    Y_WIDTH       = 7,
    parameter int                    ADDRESS_WIDTH = 15,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    SIZE          = 2,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR      = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    boid_fb_writer_if.slave bus
);
    localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;
    // One extra bit so the sweep counter can hold NUM_PIXELS itself as its end marker
    localparam int CNT_WIDTH  = ADDRESS_WIDTH + 1;
    // Square offsets run 0..SIZE, SIZE being at most 4
    localparam int OFS_WIDTH  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLOT  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     busy_q;
    logic [CNT_WIDTH-1:0]     clrAddr_q, clrAddr_d;
    logic [OFS_WIDTH-1:0]     dx_q, dx_d, dy_q, dy_d;
    logic [X_WIDTH-1:0]       boidX_q, boidX_d;
    logic [Y_WIDTH-1:0]       boidY_q, boidY_d;
    logic [DATA_WIDTH-1:0]    boidColor_q, boidColor_d;
    logic                     ramWEn_q, ramWEn_d;
    logic [ADDRESS_WIDTH-1:0] ramAddr_q, ramAddr_d;
    logic [DATA_WIDTH-1:0]    ramData_q, ramData_d;
    logic                     clearDone_q, clearDone_d;

    logic                     accept;
    logic                     clearLast;
    logic                     plotLast;
    logic [OFS_WIDTH-1:0]     curDx, curDy, nextDx, nextDy;
    logic [31:0]              pixX, pixY;
    logic                     pixOnScreen;
    logic [ADDRESS_WIDTH-1:0] pixAddr;

    assign bus.boid_ready = (state_q == IDLE) && !bus.frame_start && reset_n;
    assign accept         = bus.boid_valid && bus.boid_ready;

    // The sweep has issued every address once the counter reaches NUM_PIXELS
    assign clearLast = (state_q == CLEAR) && (clrAddr_q == CNT_WIDTH'(NUM_PIXELS));
    // dy reaching SIZE means every pixel of the square has had its cycle
    assign plotLast  = (state_q == PLOT) && (32'(dy_q) == 32'(SIZE));

    // Pixel for the next write: the first one comes straight from the handshake inputs,
    // later ones from the latched boid; also works out the offsets of the pixel after it
    always_comb begin
        curDx = '0;
        curDy = '0;
        pixX  = 32'(bus.boid_x);
        pixY  = 32'(bus.boid_y);
        if (state_q == PLOT) begin
            curDx = dx_q;
            curDy = dy_q;
            pixX  = 32'(boidX_q) + 32'(dx_q);
            pixY  = 32'(boidY_q) + 32'(dy_q);
        end
        if (32'(curDx) == 32'(SIZE - 1)) begin
            nextDx = '0;
            nextDy = curDy + OFS_WIDTH'(1);
        end else begin
            nextDx = curDx + OFS_WIDTH'(1);
            nextDy = curDy;
        end
    end

    // Pixels past the right or bottom edge are skipped, never wrapped
    assign pixOnScreen = (pixX < 32'(SCREEN_W)) && (pixY < 32'(SCREEN_H));
    assign pixAddr     = ADDRESS_WIDTH'(pixY * 32'(SCREEN_W) + pixX);

    // State register; busy is registered alongside so it tracks the state exactly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next state: frame_start restarts the clear from any state, ahead of a handshake
    always_comb begin
        state_d = state_q;
        if (bus.frame_start) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = PLOT;
                CLEAR:   if (clearLast) state_d = IDLE;
                PLOT:    if (plotLast) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the RAM port, the sweep/offset counters and the latched boid;
    // address and data hold whenever no write is issued
    always_comb begin
        ramWEn_d    = 1'b0;
        ramAddr_d   = ramAddr_q;
        ramData_d   = ramData_q;
        clearDone_d = 1'b0;
        clrAddr_d   = clrAddr_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        boidX_d     = boidX_q;
        boidY_d     = boidY_q;
        boidColor_d = boidColor_q;
        if (bus.frame_start) begin
            ramWEn_d  = 1'b1;
            ramAddr_d = '0;
            ramData_d = BG_COLOR;
            clrAddr_d = CNT_WIDTH'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        boidX_d     = bus.boid_x;
                        boidY_d     = bus.boid_y;
                        boidColor_d = bus.boid_color;
                        dx_d        = nextDx;
                        dy_d        = nextDy;
                        ramWEn_d    = pixOnScreen;
                        if (pixOnScreen) begin
                            ramAddr_d = pixAddr;
                            ramData_d = bus.boid_color;
                        end
                    end
                end
                CLEAR: begin
                    if (clearLast) begin
                        clearDone_d = 1'b1;
                    end else begin
                        ramWEn_d  = 1'b1;
                        ramAddr_d = clrAddr_q[ADDRESS_WIDTH-1:0];
                        ramData_d = BG_COLOR;
                        clrAddr_d = clrAddr_q + CNT_WIDTH'(1);
                    end
                end
                PLOT: begin
                    if (!plotLast) begin
                        dx_d     = nextDx;
                        dy_d     = nextDy;
                        ramWEn_d = pixOnScreen;
                        if (pixOnScreen) begin
                            ramAddr_d = pixAddr;
                            ramData_d = boidColor_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; reset drops the write enable at once and loses any boid or sweep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ramWEn_q    <= 1'b0;
            ramAddr_q   <= '0;
            ramData_q   <= '0;
            clearDone_q <= 1'b0;
            clrAddr_q   <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            boidX_q     <= '0;
            boidY_q     <= '0;
            boidColor_q <= '0;
        end else begin
            ramWEn_q    <= ramWEn_d;
            ramAddr_q   <= ramAddr_d;
            ramData_q   <= ramData_d;
            clearDone_q <= clearDone_d;
            clrAddr_q   <= clrAddr_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            boidX_q     <= boidX_d;
            boidY_q     <= boidY_d;
            boidColor_q <= boidColor_d;
        end
    end

    assign bus.ram_wEn    = ramWEn_q;
    assign bus.ram_addr   = ramAddr_q;
    assign bus.ram_dataIn = ramData_q;
    assign bus.busy       = busy_q;
    assign bus.clear_done = clearDone_q;
endmodule
